// File: rtl/bcd_ndigit_add_sub_serial.sv
// Digit-serial N-digit BCD adder/subtractor with start/done handshake.
// Subtraction produces a signed-magnitude result. A negative difference is
// re-complemented in a second digit-serial pass.
module bcd_ndigit_add_sub_serial #(
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [4*DIGITS-1:0]   bcd_x,
    input  logic [4*DIGITS-1:0]   bcd_y,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_r,
    output logic                  kout,
    output logic                  err
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [W-1:0]  x_q, y_q, work, work_nxt;
    logic          mode_q, carry, c_nxt, last, in_bad;
    logic [IW-1:0] idx;
    logic [3:0]    op_a, op_b, dig;
    logic [4:0]    sum;

    function automatic logic has_bad(input logic [W-1:0] v);
        logic b;
        b = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (v[4*i +: 4] > 4'd9) b = 1'b1;
        end
        return b;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Digit adder with decimal correction and next-state decode
    always_comb begin
        op_a = x_q[3:0];
        op_b = mode_q ? (4'd9 - y_q[3:0]) : y_q[3:0];
        if (state == S_FIX) begin
            op_a = 4'd9 - work[3:0];
            op_b = 4'd0;
        end
        sum = 5'(op_a) + 5'(op_b) + 5'(carry);
        if (sum > 5'd9) begin
            dig   = 4'(sum - 5'd10);
            c_nxt = 1'b1;
        end else begin
            dig   = sum[3:0];
            c_nxt = 1'b0;
        end
        work_nxt  = W'({dig, work} >> 4);
        last      = (idx == LAST_IDX);
        in_bad    = has_bad(bcd_x) | has_bad(bcd_y);
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = in_bad ? S_DONE : S_CALC;
            S_CALC: if (last) state_nxt = (!mode_q || c_nxt) ? S_DONE : S_FIX;
            S_FIX:  if (last) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand latches, work register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            work   <= '0;
            mode_q <= 1'b0;
            carry  <= 1'b0;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            bcd_r  <= '0;
            kout   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_q    <= bcd_x;
                        y_q    <= bcd_y;
                        mode_q <= mode;
                        carry  <= mode;
                        idx    <= '0;
                        work   <= '0;
                        busy   <= 1'b1;
                        if (in_bad) begin
                            bcd_r <= '0;
                            kout  <= 1'b0;
                            err   <= 1'b1;
                            done  <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    work  <= work_nxt;
                    carry <= c_nxt;
                    x_q   <= x_q >> 4;
                    y_q   <= y_q >> 4;
                    idx   <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        if (!mode_q || c_nxt) begin
                            bcd_r <= work_nxt;
                            kout  <= mode_q ? 1'b0 : c_nxt;
                            err   <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            // negative difference: seed the 10's complement pass
                            carry <= 1'b1;
                        end
                    end
                end
                S_FIX: begin
                    work  <= work_nxt;
                    carry <= c_nxt;
                    idx   <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        bcd_r <= work_nxt;
                        kout  <= 1'b1;
                        err   <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: busy <= 1'b0;
                default: busy <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_ndigit_add_sub_serial.sv
// Self-checking bench: three widths (3, 1, 8 digits) against an integer reference model.
module tb_bcd_ndigit_add_sub_serial;

    logic clk = 1'b0;
    logic rst;
    logic mv;
    logic [31:0] xv, yv;
    logic start3, start1, start8;
    logic busy3, done3, kout3, err3;
    logic busy1, done1, kout1, err1;
    logic busy8, done8, kout8, err8;
    logic [11:0] r3;
    logic [3:0]  r1;
    logic [31:0] r8;

    int cur;
    logic        done_m, busy_m, kout_m, err_m;
    logic [31:0] r_m;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_ndigit_add_sub_serial #(.DIGITS(3)) u_d3 (
        .clk(clk), .rst(rst), .start(start3), .mode(mv),
        .bcd_x(xv[11:0]), .bcd_y(yv[11:0]),
        .busy(busy3), .done(done3), .bcd_r(r3), .kout(kout3), .err(err3));

    bcd_ndigit_add_sub_serial #(.DIGITS(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mv),
        .bcd_x(xv[3:0]), .bcd_y(yv[3:0]),
        .busy(busy1), .done(done1), .bcd_r(r1), .kout(kout1), .err(err1));

    bcd_ndigit_add_sub_serial #(.DIGITS(8)) u_d8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mv),
        .bcd_x(xv), .bcd_y(yv),
        .busy(busy8), .done(done8), .bcd_r(r8), .kout(kout8), .err(err8));

    always_comb begin
        case (cur)
            1: begin done_m = done1; busy_m = busy1; kout_m = kout1; err_m = err1; r_m = {28'd0, r1}; end
            2: begin done_m = done8; busy_m = busy8; kout_m = kout8; err_m = err8; r_m = r8; end
            default: begin done_m = done3; busy_m = busy3; kout_m = kout3; err_m = err3; r_m = {20'd0, r3}; end
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int digits_of(input int sel);
        return (sel == 1) ? 1 : (sel == 2) ? 8 : 3;
    endfunction

    function automatic longint bcd2int(input logic [31:0] v, input int d);
        longint acc = 0;
        for (int i = d - 1; i >= 0; i--) acc = acc * 10 + longint'(v[4*i +: 4]);
        return acc;
    endfunction

    function automatic logic [31:0] int2bcd(input longint n, input int d);
        logic [31:0] r = '0;
        longint t = n;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic any_bad(input logic [31:0] v, input int d);
        logic b = 1'b0;
        for (int i = 0; i < d; i++) if (v[4*i +: 4] > 4'd9) b = 1'b1;
        return b;
    endfunction

    function automatic longint pow10(input int d);
        longint p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    task automatic set_start(input int sel, input logic v);
        case (sel)
            1: start1 = v;
            2: start8 = v;
            default: start3 = v;
        endcase
    endtask

    // One accepted operation, checked against the arithmetic model at done
    task automatic run_op(input int sel, input logic [31:0] x, input logic [31:0] y,
                          input logic m, input string tag, output logic [31:0] r_out);
        int d, el, cyc;
        longint xi, yi, p, s;
        logic [31:0] er;
        logic ek, ee;
        d  = digits_of(sel);
        p  = pow10(d);
        xi = bcd2int(x, d);
        yi = bcd2int(y, d);
        ee = any_bad(x, d) | any_bad(y, d);
        if (ee) begin
            er = '0; ek = 1'b0; el = 1;
        end else if (!m) begin
            s = xi + yi; er = int2bcd(s % p, d); ek = (s >= p); el = d + 1;
        end else if (xi >= yi) begin
            er = int2bcd(xi - yi, d); ek = 1'b0; el = d + 1;
        end else begin
            er = int2bcd(yi - xi, d); ek = 1'b1; el = 2 * d + 1;
        end
        cur = sel;
        @(negedge clk);
        xv = x; yv = y; mv = m;
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        cyc = 1;
        while (!done_m && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(el));
        check({tag, "_bcd_r"}, 64'(r_m), 64'(er));
        check({tag, "_kout"}, 64'(kout_m), 64'(ek));
        check({tag, "_err"}, 64'(err_m), 64'(ee));
        check({tag, "_busy_at_done"}, 64'(busy_m), 64'd1);
        r_out = r_m;
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'({done_m, busy_m}), 64'd0);
    endtask

    function automatic logic [31:0] rand_bcd(input int d);
        logic [31:0] v = '0;
        for (int i = 0; i < d; i++) begin
            if ($urandom_range(0, 11) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
            else                            v[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    initial begin
        logic [31:0] r, rx, ry;
        int cnt;
        rst = 1'b1; start3 = 1'b0; start1 = 1'b0; start8 = 1'b0;
        mv = 1'b0; xv = '0; yv = '0; cur = 0;
        repeat (3) @(negedge clk);
        check("reset_d3", 64'({busy3, done3, kout3, err3, r3}), 64'd0);
        check("reset_d1", 64'({busy1, done1, kout1, err1, r1}), 64'd0);
        check("reset_d8", 64'({busy8, done8, kout8, err8, r8}), 64'd0);
        rst = 1'b0;

        run_op(0, 32'h999, 32'h999, 1'b0, "add_999_999", r);
        check("add_999_999_literal", 64'(r), 64'h998);
        run_op(0, 32'h000, 32'h000, 1'b0, "add_000_000", r);
        run_op(0, 32'h548, 32'h459, 1'b0, "add_548_459", r);
        run_op(0, 32'h999, 32'h999, 1'b1, "sub_999_999", r);
        run_op(0, 32'h569, 32'h568, 1'b1, "sub_569_568", r);
        run_op(0, 32'h108, 32'h051, 1'b1, "sub_108_051", r);
        run_op(0, 32'h387, 32'h616, 1'b1, "sub_387_616", r);
        check("sub_387_616_literal", 64'(r), 64'h229);
        run_op(0, 32'h765, 32'h943, 1'b1, "sub_765_943", r);
        run_op(0, 32'h9A0, 32'h123, 1'b0, "err_9a0", r);
        run_op(0, 32'h123, 32'h045, 1'b0, "after_err", r);
        repeat (3) @(negedge clk);
        check("result_hold", 64'(r3), 64'h168);

        // start held/re-pulsed while busy, operands disturbed after acceptance
        cur = 0; cnt = 0;
        @(negedge clk);
        xv = 32'h250; yv = 32'h125; mv = 1'b1; start3 = 1'b1;
        r = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 2) begin xv = 32'h999; yv = 32'h001; mv = 1'b0; end
            if (c == 3) start3 = 1'b0;
            if (c == 4) start3 = 1'b1;
            if (c == 5) start3 = 1'b0;
            if (done3) begin cnt++; r = {20'd0, r3}; end
        end
        check("held_start_done_count", 64'(cnt), 64'd1);
        check("held_start_result", 64'(r), 64'h125);

        // reset in the middle of CALC aborts the operation
        cnt = 0;
        @(negedge clk);
        xv = 32'h111; yv = 32'h222; mv = 1'b0; start3 = 1'b1;
        @(negedge clk); start3 = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("midop_reset_outputs", 64'({busy3, done3, kout3, err3, r3}), 64'd0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done3) cnt++;
        end
        check("midop_reset_no_done", 64'(cnt), 64'd0);
        run_op(0, 32'h387, 32'h616, 1'b1, "after_reset", r);

        run_op(1, 32'h5, 32'h7, 1'b0, "d1_add_5_7", r);
        check("d1_add_5_7_literal", 64'(r), 64'h2);
        run_op(1, 32'h3, 32'h8, 1'b1, "d1_sub_3_8", r);
        run_op(1, 32'hB, 32'h1, 1'b0, "d1_err", r);
        run_op(2, 32'h00000005, 32'h00000007, 1'b0, "d8_add_5_7", r);
        run_op(2, 32'h00000001, 32'h00000002, 1'b1, "d8_sub_1_2", r);
        check("d8_sub_1_2_literal", 64'(r), 64'h00000001);
        run_op(2, 32'h99999999, 32'h00000001, 1'b0, "d8_add_wrap", r);

        for (int sel = 0; sel < 3; sel++) begin
            for (int k = 0; k < 12; k++) begin
                rx = rand_bcd(digits_of(sel));
                ry = rand_bcd(digits_of(sel));
                run_op(sel, rx, ry, 1'($urandom_range(0, 1)), $sformatf("rand_s%0d_%0d", sel, k), r);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
